// File: rtl/tess_pkg.sv
// Shared constants, FSM state encoding and the reciprocal table for the tessellation domain generator.
package tess_pkg;
   localparam int TF_W = 8;
   localparam int TMAX = 64;
   localparam int UV_W = 17;
   localparam int RW   = $clog2(TMAX + 1);

   localparam logic [UV_W-1:0] UV_ONE = 17'h10000;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EDGE     = 2'd1,
      ST_INTERIOR = 2'd2
   } tess_state_e;

   typedef logic [TMAX:0][UV_W-1:0] recip_tbl_t;

   // Entry N holds round(65536/N); entry 0 is never addressed because factors are clamped to >= 1.
   function automatic recip_tbl_t build_recip();
      recip_tbl_t t;
      t[0] = '0;
      for (int n = 1; n <= TMAX; n++) begin
         t[n] = UV_W'((65536 + n / 2) / n);
      end
      return t;
   endfunction

   localparam recip_tbl_t RECIP = build_recip();
endpackage

// File: rtl/tess_frac.sv
// Combinational fraction idx/n as idx*RECIP[n], saturated at 1.0, optionally complemented to 1.0 - idx/n.
module tess_frac
   import tess_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input  logic [IDX_W-1:0] idx,
   input  logic [IDX_W-1:0] n,
   input  logic             comp,
   output logic [UV_W-1:0]  frac
);
   logic [IDX_W+UV_W-1:0] prod;
   logic [UV_W-1:0]       sat;

   always_comb begin
      prod = (IDX_W+UV_W)'(idx) * (IDX_W+UV_W)'(RECIP[RW'(n)]);
      sat  = (prod > (IDX_W+UV_W)'(UV_ONE)) ? UV_ONE : prod[UV_W-1:0];
      frac = comp ? (UV_ONE - sat) : sat;
   end
endmodule

// File: rtl/tess_domain_gen.sv
// Quad-domain point generator: perimeter edges 0..3, then the interior grid, one point per accepted cycle.
// Optional TESS_DOMAIN_STATS_EN adds patch_cnt/point_cnt counters.
module tess_domain_gen #(
   parameter int TF_W = tess_pkg::TF_W,
   parameter int TMAX = tess_pkg::TMAX,
   parameter int UV_W = tess_pkg::UV_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [TF_W-1:0] outer0,
   input  logic [TF_W-1:0] outer1,
   input  logic [TF_W-1:0] outer2,
   input  logic [TF_W-1:0] outer3,
   input  logic [TF_W-1:0] inner0,
   input  logic [TF_W-1:0] inner1,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [UV_W-1:0] out_u,
   output logic [UV_W-1:0] out_v,
   output logic            out_edge,
   output logic            out_last,
`ifdef TESS_DOMAIN_STATS_EN
   output logic [31:0]     patch_cnt,
   output logic [31:0]     point_cnt,
`endif
   output tess_pkg::tess_state_e fsm_state
);
   import tess_pkg::*;

   // Handshakes: a transfer happens on a rising clk edge where valid && ready; the producer holds
   // its payload stable while valid is high and ready is low.
   localparam logic [TF_W-1:0] ONE_F = TF_W'(1);

   tess_state_e     state;
   logic [TF_W-1:0] f_out [4];
   logic [TF_W-1:0] f_in0, f_in1;
   logic [1:0]      k;
   logic [TF_W-1:0] i, j;
   logic [UV_W-1:0] v_acc;

   tess_state_e     nstate;
   logic [1:0]      nk;
   logic [TF_W-1:0] ni, nj;
   logic [UV_W-1:0] nv_acc, nu, nv;
   logic            n_edge, n_last;
   logic [TF_W-1:0] fr_n;
   logic            fr_comp;
   logic [UV_W-1:0] fr_val;
   logic            advance, no_interior;

   function automatic logic [TF_W-1:0] clamp(input logic [TF_W-1:0] f);
      if (f == '0) return ONE_F;
      if (f > TF_W'(TMAX)) return TF_W'(TMAX);
      return f;
   endfunction

   assign in_ready    = (state == ST_IDLE);
   assign fsm_state   = state;
   assign advance     = out_valid && out_ready;
   assign no_interior = (f_in0 == ONE_F) || (f_in1 == ONE_F);

   // Position of the point that follows the one currently presented.
   always_comb begin
      nstate = state;
      nk     = k;
      ni     = i;
      nj     = j;
      nv_acc = v_acc;
      case (state)
         ST_EDGE: begin
            if (i != f_out[k] - ONE_F) begin
               ni = i + ONE_F;
            end else if (k != 2'd3) begin
               nk = k + 2'd1;
               ni = '0;
            end else if (no_interior) begin
               nstate = ST_IDLE;
            end else begin
               nstate = ST_INTERIOR;
               ni     = ONE_F;
               nj     = ONE_F;
               nv_acc = RECIP[RW'(f_in1)];
            end
         end
         ST_INTERIOR: begin
            if (i != f_in0 - ONE_F) begin
               ni = i + ONE_F;
            end else if (j != f_in1 - ONE_F) begin
               nj     = j + ONE_F;
               ni     = ONE_F;
               nv_acc = v_acc + RECIP[RW'(f_in1)];
            end else begin
               nstate = ST_IDLE;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      fr_n    = (nstate == ST_EDGE) ? f_out[nk] : f_in0;
      fr_comp = (nstate == ST_EDGE) && nk[1];
   end

   tess_frac #(.IDX_W(TF_W)) u_frac (
      .idx  (ni),
      .n    (fr_n),
      .comp (fr_comp),
      .frac (fr_val)
   );

   // Interior v is a running sum of RECIP[inner1], equal to j*RECIP[inner1] without a second multiplier.
   always_comb begin
      nu     = '0;
      nv     = '0;
      n_edge = 1'b1;
      n_last = 1'b0;
      if (nstate == ST_EDGE) begin
         case (nk)
            2'd0: nu = fr_val;
            2'd1: begin nu = UV_ONE; nv = fr_val; end
            2'd2: begin nu = fr_val; nv = UV_ONE; end
            default: nv = fr_val;
         endcase
         n_last = (nk == 2'd3) && (ni == f_out[3] - ONE_F) && no_interior;
      end else begin
         nu     = fr_val;
         nv     = nv_acc;
         n_edge = 1'b0;
         n_last = (ni == f_in0 - ONE_F) && (nj == f_in1 - ONE_F);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         out_u     <= '0;
         out_v     <= '0;
         out_edge  <= 1'b0;
         out_last  <= 1'b0;
         k         <= '0;
         i         <= '0;
         j         <= '0;
         v_acc     <= '0;
         for (int n = 0; n < 4; n++) f_out[n] <= ONE_F;
         f_in0     <= ONE_F;
         f_in1     <= ONE_F;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  f_out[0]  <= clamp(outer0);
                  f_out[1]  <= clamp(outer1);
                  f_out[2]  <= clamp(outer2);
                  f_out[3]  <= clamp(outer3);
                  f_in0     <= clamp(inner0);
                  f_in1     <= clamp(inner1);
                  state     <= ST_EDGE;
                  k         <= '0;
                  i         <= '0;
                  j         <= '0;
                  out_valid <= 1'b1;
                  out_u     <= '0;
                  out_v     <= '0;
                  out_edge  <= 1'b1;
                  out_last  <= 1'b0;
               end
            end
            default: begin
               if (advance) begin
                  state <= nstate;
                  k     <= nk;
                  i     <= ni;
                  j     <= nj;
                  v_acc <= nv_acc;
                  if (nstate == ST_IDLE) begin
                     out_valid <= 1'b0;
                     out_u     <= '0;
                     out_v     <= '0;
                     out_edge  <= 1'b0;
                     out_last  <= 1'b0;
                  end else begin
                     out_u    <= nu;
                     out_v    <= nv;
                     out_edge <= n_edge;
                     out_last <= n_last;
                  end
               end
            end
         endcase
      end
   end

`ifdef TESS_DOMAIN_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         patch_cnt <= '0;
         point_cnt <= '0;
      end else begin
         if (in_valid && in_ready) patch_cnt <= patch_cnt + 32'd1;
         if (advance) point_cnt <= point_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_tess_domain_gen.sv
// Bench for tess_domain_gen: vector table, hand-written corner sequences and random patches vs a point-list model.
module tb_tess_domain_gen;
   import tess_pkg::*;

   localparam int W = 36;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  outer0 = '0, outer1 = '0, outer2 = '0, outer3 = '0;
   logic [7:0]  inner0 = '0, inner1 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [16:0] out_u, out_v;
   logic        out_edge, out_last;
   tess_state_e fsm_state;
`ifdef TESS_DOMAIN_STATS_EN
   logic [31:0] patch_cnt, point_cnt;
`endif

   always #5 clk = ~clk;

   tess_domain_gen dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .outer0    (outer0),
      .outer1    (outer1),
      .outer2    (outer2),
      .outer3    (outer3),
      .inner0    (inner0),
      .inner1    (inner1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_u     (out_u),
      .out_v     (out_v),
      .out_edge  (out_edge),
      .out_last  (out_last),
`ifdef TESS_DOMAIN_STATS_EN
      .patch_cnt (patch_cnt),
      .point_cnt (point_cnt),
`endif
      .fsm_state (fsm_state)
   );

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int failures = 0;
   int patch_exp = 0;
   int point_exp = 0;

   typedef struct {
      int           f[6];
      int           npts;
      logic [W-1:0] last_pt;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] pt(input int u, input int v, input bit e, input bit l);
      return {17'(u), 17'(v), e, l};
   endfunction

   function automatic int clampf(input int f);
      if (f == 0) return 1;
      if (f > TMAX) return TMAX;
      return f;
   endfunction

   // i/n in UQ1.16 via the rounded reciprocal of n.
   function automatic int fracm(input int i, input int n);
      return i * ((65536 + n / 2) / n);
   endfunction

   task automatic fill_model(input int a0, input int a1, input int a2, input int a3,
                             input int b0, input int b1);
      int o[4];
      int n0, n1, s;
      o[0] = clampf(a0); o[1] = clampf(a1); o[2] = clampf(a2); o[3] = clampf(a3);
      n0 = clampf(b0);
      n1 = clampf(b1);
      for (int e = 0; e < 4; e++) begin
         for (int x = 0; x < o[e]; x++) begin
            s = fracm(x, o[e]);
            case (e)
               0: exp_q.push_back(pt(s, 0, 1'b1, 1'b0));
               1: exp_q.push_back(pt(65536, s, 1'b1, 1'b0));
               2: exp_q.push_back(pt(65536 - s, 65536, 1'b1, 1'b0));
               default: exp_q.push_back(pt(0, 65536 - s, 1'b1, 1'b0));
            endcase
         end
      end
      for (int y = 1; y < n1; y++) begin
         for (int x = 1; x < n0; x++) begin
            exp_q.push_back(pt(fracm(x, n0), fracm(y, n1), 1'b0, 1'b0));
         end
      end
      exp_q[exp_q.size()-1][0] = 1'b1;
   endtask

   // Called at a sample point (#1 after a rising edge); leaves the bench at a sample point.
   task automatic run_patch(input int a0, input int a1, input int a2, input int a3,
                            input int b0, input int b1, input int pct, input int abort_after,
                            output int npts, output logic [W-1:0] last_act);
      logic [W-1:0] held, act;
      bit stalled;
      int budget;
      npts = 0;
      stalled = 0;
      budget = 0;
      last_act = '0;
      check("in_ready_before_patch", in_ready, 1);
      in_valid = 1'b1;
      outer0 = 8'(a0); outer1 = 8'(a1); outer2 = 8'(a2); outer3 = 8'(a3);
      inner0 = 8'(b0); inner1 = 8'(b1);
      patch_exp++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("first_valid_after_capture", out_valid, 1);
      while (exp_q.size() > 0) begin
         act = {out_u, out_v, out_edge, out_last};
         check("no_bubble", out_valid, 1);
         if (stalled) check("stall_hold", act, held);
         out_ready = ($urandom_range(99) < pct);
         if (out_ready) begin
            check("point", act, exp_q.pop_front());
            npts++;
            point_exp++;
            last_act = act;
            stalled = 0;
         end else begin
            held = act;
            stalled = 1;
         end
         @(posedge clk); #1;
         budget++;
         if (abort_after >= 0 && npts == abort_after) begin
            out_ready = 1'b0;
            return;
         end
         if (budget > 30000) begin
            failures++;
            $display("FAIL patch_timeout actual=%0d required<=30000 cycles", budget);
            exp_q.delete();
         end
      end
      out_ready = 1'b0;
      check("out_valid_low_after_last", out_valid, 0);
      check("in_ready_after_last", in_ready, 1);
   endtask

   initial begin
      int n;
      logic [W-1:0] lp;
      int f[6];

      vecs[0] = '{f: '{1, 1, 1, 1, 1, 1},       npts: 4,    last_pt: pt(0, 65536, 1'b1, 1'b1)};
      vecs[1] = '{f: '{2, 1, 1, 1, 2, 2},       npts: 6,    last_pt: pt(32768, 32768, 1'b0, 1'b1)};
      vecs[2] = '{f: '{0, 1, 1, 1, 200, 1},     npts: 4,    last_pt: pt(0, 65536, 1'b1, 1'b1)};
      vecs[3] = '{f: '{3, 3, 3, 3, 3, 3},       npts: 16,   last_pt: pt(43690, 43690, 1'b0, 1'b1)};
      vecs[4] = '{f: '{5, 2, 7, 1, 1, 9},       npts: 15,   last_pt: pt(0, 65536, 1'b1, 1'b1)};
      vecs[5] = '{f: '{64, 64, 64, 64, 64, 64}, npts: 4225, last_pt: pt(64512, 64512, 1'b0, 1'b1)};

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_u", out_u, 0);
      check("rst_out_v", out_v, 0);
      check("rst_out_edge", out_edge, 0);
      check("rst_out_last", out_last, 0);
      check("rst_fsm_state", fsm_state, ST_IDLE);
      rst = 1'b0;
      @(posedge clk); #1;

      // Table of patches, full-rate downstream, back-to-back
      for (int t = 0; t < 6; t++) begin
         exp_q.delete();
         fill_model(vecs[t].f[0], vecs[t].f[1], vecs[t].f[2], vecs[t].f[3], vecs[t].f[4], vecs[t].f[5]);
         run_patch(vecs[t].f[0], vecs[t].f[1], vecs[t].f[2], vecs[t].f[3], vecs[t].f[4], vecs[t].f[5],
                   100, -1, n, lp);
         check($sformatf("vec%0d_point_count", t), n, vecs[t].npts);
         check($sformatf("vec%0d_last_point", t), lp, vecs[t].last_pt);
      end

      // Hand-listed six-point patch, then the same with random stalls
      for (int r = 0; r < 2; r++) begin
         exp_q.delete();
         exp_q.push_back(pt(0, 0, 1'b1, 1'b0));
         exp_q.push_back(pt(32768, 0, 1'b1, 1'b0));
         exp_q.push_back(pt(65536, 0, 1'b1, 1'b0));
         exp_q.push_back(pt(65536, 65536, 1'b1, 1'b0));
         exp_q.push_back(pt(0, 65536, 1'b1, 1'b0));
         exp_q.push_back(pt(32768, 32768, 1'b0, 1'b1));
         run_patch(2, 1, 1, 1, 2, 2, (r == 0) ? 100 : 50, -1, n, lp);
         check("six_point_count", n, 6);
      end

      // Two maximal patches back to back
      for (int r = 0; r < 2; r++) begin
         exp_q.delete();
         fill_model(64, 64, 64, 64, 64, 64);
         run_patch(64, 64, 64, 64, 64, 64, 100, -1, n, lp);
         check("max_patch_count", n, 4225);
      end

      // Reset in the middle of a maximal patch
      exp_q.delete();
      fill_model(64, 64, 64, 64, 64, 64);
      run_patch(64, 64, 64, 64, 64, 64, 100, 3, n, lp);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_out_u", out_u, 0);
      check("abort_out_last", out_last, 0);
      rst = 1'b0;
      patch_exp = 0;
      point_exp = 0;
      exp_q.delete();
      fill_model(1, 1, 1, 1, 1, 1);
      run_patch(1, 1, 1, 1, 1, 1, 100, -1, n, lp);
      check("after_abort_count", n, 4);

      // Random patches with random downstream stalls
      for (int r = 0; r < 12; r++) begin
         for (int q = 0; q < 4; q++) f[q] = ($urandom_range(3) == 0) ? $urandom_range(255) : $urandom_range(10);
         f[4] = ($urandom_range(4) == 0) ? $urandom_range(255) : $urandom_range(12);
         f[5] = $urandom_range(12);
         exp_q.delete();
         fill_model(f[0], f[1], f[2], f[3], f[4], f[5]);
         run_patch(f[0], f[1], f[2], f[3], f[4], f[5], $urandom_range(100, 30), -1, n, lp);
      end

`ifdef TESS_DOMAIN_STATS_EN
      check("stats_patch_cnt", patch_cnt, 32'(patch_exp));
      check("stats_point_cnt", point_cnt, 32'(point_exp));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
